// File: rtl/systolic_sequencer.sv
// Sequencer for an NxN output-stationary systolic array: accepts A/B, clears the
// array, streams skewed operands, drains the pipeline and hands back C = A*B.
module systolic_sequencer #(
    parameter int unsigned BITWIDTH   = 4,
    parameter int unsigned N          = 4,
    parameter int unsigned OUTWIDTH   = 8,
    parameter int unsigned PE_LATENCY = 1
) (
    input  logic                                    i_clk,
    input  logic                                    i_arst,
    input  logic                                    i_inValid,
    output logic                                    o_inReady,
    input  logic [N-1:0][N-1:0][BITWIDTH-1:0]       i_matA,
    input  logic [N-1:0][N-1:0][BITWIDTH-1:0]       i_matB,
    output logic                                    o_arrayClear,
    output logic                                    o_doProcess,
    output logic [N-1:0][BITWIDTH-1:0]              o_row,
    output logic [N-1:0][BITWIDTH-1:0]              o_col,
    input  logic [N-1:0][N-1:0][OUTWIDTH-1:0]       i_c,
    output logic                                    o_outValid,
    input  logic                                    i_outReady,
    output logic [N-1:0][N-1:0][OUTWIDTH-1:0]       o_result,
    output logic                                    o_busy
);

    localparam int unsigned FEED_CYCLES = 3 * N - 2;
    localparam int unsigned CNT_MAX     = (FEED_CYCLES > PE_LATENCY) ? FEED_CYCLES : PE_LATENCY;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    typedef logic [N-1:0][BITWIDTH-1:0] vec_t;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                              state;
    logic [CNT_W-1:0]                    cnt;
    logic [N-1:0][N-1:0][BITWIDTH-1:0]   mat_a;
    logic [N-1:0][N-1:0][BITWIDTH-1:0]   mat_b;

    // Row i carries A[i][k] on the diagonal step t = i + k.
    function automatic vec_t row_at(input logic [CNT_W-1:0] t);
        row_at = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < int'(N); k++) begin
                if (int'(t) == i + k) row_at[i] = mat_a[i][k];
            end
        end
    endfunction

    // Column j carries B[k][j] on the diagonal step t = k + j.
    function automatic vec_t col_at(input logic [CNT_W-1:0] t);
        col_at = '0;
        for (int j = 0; j < int'(N); j++) begin
            for (int k = 0; k < int'(N); k++) begin
                if (int'(t) == k + j) col_at[j] = mat_b[k][j];
            end
        end
    endfunction

    // Outputs are registered alongside the state so each phase presents its own values.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state        <= IDLE;
            cnt          <= '0;
            mat_a        <= '0;
            mat_b        <= '0;
            o_inReady    <= 1'b1;
            o_arrayClear <= 1'b0;
            o_doProcess  <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
            o_outValid   <= 1'b0;
            o_result     <= '0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_inValid && o_inReady) begin
                        mat_a        <= i_matA;
                        mat_b        <= i_matB;
                        state        <= CLEAR;
                        o_inReady    <= 1'b0;
                        o_busy       <= 1'b1;
                        o_arrayClear <= 1'b1;
                    end
                end
                CLEAR: begin
                    state        <= FEED;
                    cnt          <= '0;
                    o_arrayClear <= 1'b0;
                    o_doProcess  <= 1'b1;
                    o_row        <= row_at('0);
                    o_col        <= col_at('0);
                end
                FEED: begin
                    if (cnt == CNT_W'(FEED_CYCLES - 1)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        o_row <= '0;
                        o_col <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        o_row <= row_at(cnt + CNT_W'(1));
                        o_col <= col_at(cnt + CNT_W'(1));
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_W'(PE_LATENCY - 1)) begin
                        state       <= DONE;
                        cnt         <= '0;
                        o_doProcess <= 1'b0;
                        o_result    <= i_c;
                        o_outValid  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (o_outValid && i_outReady) begin
                        state      <= IDLE;
                        o_outValid <= 1'b0;
                        o_busy     <= 1'b0;
                        o_inReady  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: a behavioural systolic array closes the loop and a
// scoreboard of reference products is checked against each delivered result.
module tb_systolic_sequencer;

    localparam int BW = 4;
    localparam int N  = 4;
    localparam int OW = 8;
    localparam int PL = 1;

    typedef logic [N-1:0][N-1:0][BW-1:0] mat_in_t;
    typedef logic [N-1:0][N-1:0][OW-1:0] mat_out_t;
    typedef logic [N-1:0][BW-1:0]        vec_t;

    logic     clk = 1'b0;
    logic     i_arst, i_inValid, i_outReady;
    mat_in_t  i_matA, i_matB;
    mat_out_t i_c;
    logic     o_inReady, o_arrayClear, o_doProcess, o_outValid, o_busy;
    vec_t     o_row, o_col;
    mat_out_t o_result;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int accept_cyc = 0;
    mat_out_t exp_q[$];

    systolic_sequencer #(.BITWIDTH(BW), .N(N), .OUTWIDTH(OW), .PE_LATENCY(PL)) dut (
        .i_clk(clk), .i_arst(i_arst), .i_inValid(i_inValid), .o_inReady(o_inReady),
        .i_matA(i_matA), .i_matB(i_matB), .o_arrayClear(o_arrayClear),
        .o_doProcess(o_doProcess), .o_row(o_row), .o_col(o_col), .i_c(i_c),
        .o_outValid(o_outValid), .i_outReady(i_outReady), .o_result(o_result),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array: A flows right, B flows down.
    logic [N-1:0][N-1:0][BW-1:0] pa, pb, a_w, b_w;
    mat_out_t acc;
    always_comb begin
        a_w = '0;
        b_w = '0;
        for (int i = 0; i < N; i++) begin
            a_w[i][0] = o_row[i];
            b_w[0][i] = o_col[i];
            for (int j = 1; j < N; j++) begin
                a_w[i][j] = pa[i][j-1];
                b_w[j][i] = pb[j-1][i];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (i_arst || o_arrayClear) begin
            pa  <= '0;
            pb  <= '0;
            acc <= '0;
        end else if (o_doProcess) begin
            pa <= a_w;
            pb <= b_w;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= acc[i][j] + OW'(a_w[i][j]) * OW'(b_w[i][j]);
        end
    end
    assign i_c = acc;

    function automatic mat_out_t matmul(input mat_in_t a, input mat_in_t b);
        matmul = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++) s += int'(a[i][k]) * int'(b[k][j]);
                matmul[i][j] = OW'(s);
            end
    endfunction

    function automatic vec_t skew_row(input mat_in_t a, input int t);
        skew_row = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) skew_row[i] = a[i][t-i];
    endfunction

    function automatic vec_t skew_col(input mat_in_t b, input int t);
        skew_col = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) skew_col[j] = b[t-j][j];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start_job(input mat_in_t a, input mat_in_t b);
        int n = 0;
        i_matA = a;
        i_matB = b;
        i_inValid = 1'b1;
        while (!o_inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 256'(n < 200), 256'(1));
        exp_q.push_back(matmul(a, b));
        accept_cyc = cyc;
        @(negedge clk);
        i_inValid = 1'b0;
        check("accepted_busy", {o_inReady, o_busy}, 256'(2'b01));
    endtask

    task automatic finish_job(input string tag, input bit check_lat);
        int n = 0;
        mat_out_t e;
        while (!o_outValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("outvalid_wait", 256'(n < 200), 256'(1));
        if (check_lat) check({tag, "_latency"}, 256'(cyc - accept_cyc), 256'(3 * N + PL));
        check("queue_nonempty", 256'(exp_q.size() != 0), 256'(1));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check(tag, o_result, e);
        i_outReady = 1'b1;
        @(negedge clk);
        i_outReady = 1'b0;
        check({tag, "_release"}, {o_outValid, o_inReady, o_busy}, 256'(3'b010));
        check({tag, "_result_kept"}, o_result, e);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_in_t a, b, a2, b2;
        mat_out_t hold;
        i_arst = 1'b1;
        i_inValid = 1'b0;
        i_outReady = 1'b0;
        i_matA = '0;
        i_matB = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_inReady, o_busy, o_outValid, o_arrayClear, o_doProcess},
              256'(5'b10000));
        check("reset_feed", {o_row, o_col}, 256'(0));
        check("reset_result", o_result, 256'(0));
        i_arst = 1'b0;
        @(negedge clk);

        // Identity times a counting matrix
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = BW'(i == j);
                b[i][j] = BW'(i * 4 + j);
            end
        start_job(a, b);
        finish_job("identity", 1'b1);

        // All-15 operands: 900 wraps to 132
        a = '1;
        b = '1;
        start_job(a, b);
        finish_job("wrap", 1'b1);
        check("wrap_elem", o_result[2][1], 256'(132));

        // Skew window per FEED cycle
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = BW'(i + 1);
                b[i][j] = BW'(j + 1);
            end
        start_job(a, b);
        check("clear_phase", {o_arrayClear, o_doProcess, o_row, o_col}, 256'({2'b10, 32'h0}));
        for (int t = 0; t < 3 * N - 2; t++) begin
            @(negedge clk);
            check($sformatf("feed_row_t%0d", t), o_row, skew_row(a, t));
            check($sformatf("feed_col_t%0d", t), o_col, skew_col(b, t));
            check($sformatf("feed_en_t%0d", t), {o_doProcess, o_arrayClear, o_outValid},
                  256'(3'b100));
        end
        @(negedge clk);
        check("drain_phase", {o_doProcess, o_outValid, o_row, o_col}, 256'({2'b10, 32'h0}));
        finish_job("skew", 1'b0);

        // Consumer stall with a competing request
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a[i][j] = BW'($urandom_range(0, 15));
                b[i][j] = BW'($urandom_range(0, 15));
                a2[i][j] = BW'($urandom_range(0, 15));
            end
        start_job(a, b);
        while (!o_outValid && cyc - accept_cyc < 100) @(negedge clk);
        hold = (exp_q.size() != 0) ? exp_q[0] : '0;
        i_matA = a2;
        i_matB = a2;
        i_inValid = 1'b1;
        for (int s = 0; s < 20; s++) begin
            check($sformatf("stall_%0d", s), {o_outValid, o_inReady, o_busy}, 256'(3'b101));
            check($sformatf("stall_result_%0d", s), o_result, hold);
            @(negedge clk);
        end
        i_inValid = 1'b0;
        finish_job("stall", 1'b0);

        // Reset during FEED at t=5
        start_job(b, a);
        repeat (6) @(negedge clk);
        check("pre_reset_row", o_row, skew_row(b, 5));
        i_arst = 1'b1;
        @(negedge clk);
        i_arst = 1'b0;
        check("midreset_outputs", {o_inReady, o_busy, o_outValid, o_arrayClear, o_doProcess},
              256'(5'b10000));
        check("midreset_feed", {o_row, o_col}, 256'(0));
        check("midreset_result", o_result, 256'(0));
        exp_q.delete();
        start_job(a2, b);
        finish_job("after_reset", 1'b1);

        // Back-to-back with i_inValid held high
        start_job(a, a2);
        i_matA = b;
        i_matB = a;
        i_inValid = 1'b1;
        finish_job("b2b_first", 1'b1);
        exp_q.push_back(matmul(b, a));
        accept_cyc = cyc;
        @(negedge clk);
        check("b2b_accept_next", {o_inReady, o_busy}, 256'(2'b01));
        i_inValid = 1'b0;
        finish_job("b2b_second", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
